// File: rtl/combi_pkg.sv
// Shared definitions for the combi fetch stage.
// Holds the fetch FSM state type, the decode bubble word, the default reset
// PC and a small PC-increment helper used by the fetch logic.
package combi_pkg;

  localparam logic [31:0] BUBBLE           = '0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Legacy state encodings, kept so existing waveform decoders still match.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_FETCH   = ST_FETCH,
    S_DISCARD = ST_DISCARD,
    S_HOLD    = ST_HOLD
  } fetch_state_e;

  // Modulo-2^32 sequential PC step.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/combi_fetch_if.sv
// Instruction-memory bus between the fetch stage and the memory.
//   ImemAddr  : fetch -> memory, request address
//   ImemReq   : fetch -> memory, request outstanding
//   ImemRdata : memory -> fetch, returned instruction word
//   ImemValid : memory -> fetch, ImemRdata valid, completes the request
interface combi_fetch_if;

  logic [31:0] ImemAddr;
  logic        ImemReq;
  logic [31:0] ImemRdata;
  logic        ImemValid;

  modport master (
    output ImemAddr,
    output ImemReq,
    input  ImemRdata,
    input  ImemValid
  );

  modport slave (
    input  ImemAddr,
    input  ImemReq,
    output ImemRdata,
    output ImemValid
  );

endinterface

// File: rtl/combi_fetch_buf.sv
// One-entry hold buffer for a fetched instruction that decode could not take.
//   clk, reset : clock, asynchronous active-high reset
//   i_load     : capture i_instr/i_pc and mark the entry valid
//   i_clear    : drop the entry (delivered or invalidated by a redirect)
//   o_instr, o_pc, o_valid : buffered word, its PC, entry valid
module combi_fetch_buf
  import combi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= BUBBLE;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/combi_fetch.sv
// Fetch stage with decode pipeline register.
// Issues one instruction-memory request at a time, survives wait states,
// drops data belonging to a redirected path, and parks a fetched word in a
// one-entry buffer when decode stalls or is flushed.
//   clk, reset              : clock, asynchronous active-high reset
//   ImemAddr/ImemReq        : request to instruction memory (held until ImemValid)
//   ImemRdata/ImemValid     : returned word, completes the request
//   StallD/FlushD           : decode hold / decode bubble
//   PCSrcE/PCTargetE        : redirect from execute
//   armD -> ArmModeD        : registered ISA mode fed back to the decoder
//   InstrD/PCD/PCPlus4D     : decode register contents
//   wasNotFlushedD          : InstrD is a real instruction
//   FetchBusyF              : decode gets a bubble only for lack of an instruction
module combi_fetch
  import combi_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic        ARM_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ImemAddr,
  output logic        ImemReq,
  input  logic [31:0] ImemRdata,
  input  logic        ImemValid,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        armD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        wasNotFlushedD,
  output logic        ArmModeD,
  output logic        FetchBusyF
);

  fetch_state_e r_state;
  logic [31:0]  r_pcf;
  logic [31:0]  r_req_addr;
  logic [31:0]  r_instr_d;
  logic [31:0]  r_pc_d;
  logic [31:0]  r_pcplus4_d;
  logic         r_wnf_d;
  logic         r_arm_d;

  fetch_state_e w_state_nxt;
  logic [31:0]  w_pcf_nxt;
  logic [31:0]  w_req_nxt;
  logic         w_fetch_valid;
  logic         w_d_free;
  logic         w_deliver_mem;
  logic         w_deliver_buf;
  logic         w_buf_load;
  logic         w_buf_clear;
  logic [31:0]  w_buf_instr;
  logic [31:0]  w_buf_pc;
  logic         w_buf_valid;

  assign w_fetch_valid = (r_state == S_FETCH) && ImemValid;
  assign w_d_free      = !StallD && !FlushD && !PCSrcE;
  assign w_deliver_mem = w_fetch_valid && w_d_free;
  assign w_deliver_buf = (r_state == S_HOLD) && w_d_free;
  // A word that decode cannot take right now is parked rather than refetched.
  assign w_buf_load    = w_fetch_valid && !PCSrcE && (StallD || FlushD);
  assign w_buf_clear   = (r_state == S_HOLD) && (PCSrcE || w_deliver_buf);

  combi_fetch_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_instr (ImemRdata),
    .i_pc    (r_req_addr),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc),
    .o_valid (w_buf_valid)
  );

  // PCF is the next PC to fetch; ReqAddr only moves when a new request starts,
  // which keeps ImemAddr stable across wait states and in DISCARD.
  always_comb begin
    w_state_nxt = r_state;
    w_pcf_nxt   = r_pcf;
    w_req_nxt   = r_req_addr;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        if (PCSrcE) begin
          w_pcf_nxt = PCTargetE;
          w_req_nxt = PCTargetE;
        end else begin
          w_req_nxt = r_pcf;
        end
      end
      S_FETCH: begin
        if (PCSrcE) begin
          w_pcf_nxt = PCTargetE;
          if (ImemValid) w_req_nxt = PCTargetE;
          else           w_state_nxt = S_DISCARD;
        end else if (ImemValid) begin
          w_pcf_nxt = pc_plus4(r_pcf);
          if (StallD || FlushD) w_state_nxt = S_HOLD;
          else                  w_req_nxt   = pc_plus4(r_pcf);
        end
      end
      S_DISCARD: begin
        if (PCSrcE) w_pcf_nxt = PCTargetE;
        if (ImemValid) begin
          w_state_nxt = S_FETCH;
          w_req_nxt   = PCSrcE ? PCTargetE : r_pcf;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          w_pcf_nxt   = PCTargetE;
          w_req_nxt   = PCTargetE;
          w_state_nxt = S_FETCH;
        end else if (!StallD && !FlushD) begin
          w_req_nxt   = r_pcf;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pcf      <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_pcf      <= w_pcf_nxt;
      r_req_addr <= w_req_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_d   <= BUBBLE;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_wnf_d     <= 1'b0;
      r_arm_d     <= ARM_RESET;
    end else if (!StallD) begin
      r_arm_d <= armD;
      if (w_deliver_mem) begin
        r_instr_d   <= ImemRdata;
        r_pc_d      <= r_req_addr;
        r_pcplus4_d <= pc_plus4(r_req_addr);
        r_wnf_d     <= 1'b1;
      end else if (w_deliver_buf && w_buf_valid) begin
        r_instr_d   <= w_buf_instr;
        r_pc_d      <= w_buf_pc;
        r_pcplus4_d <= pc_plus4(w_buf_pc);
        r_wnf_d     <= 1'b1;
      end else begin
        r_instr_d <= BUBBLE;
        r_wnf_d   <= 1'b0;
      end
    end
  end

  assign ImemAddr       = r_req_addr;
  assign ImemReq        = (r_state == S_FETCH) || (r_state == S_DISCARD);
  assign InstrD         = r_instr_d;
  assign PCD            = r_pc_d;
  assign PCPlus4D       = r_pcplus4_d;
  assign wasNotFlushedD = r_wnf_d;
  assign ArmModeD       = r_arm_d;
  assign FetchBusyF     = w_d_free && !w_deliver_mem && !(w_deliver_buf && w_buf_valid);

endmodule

// File: tb/tb_combi_fetch.sv
// Directed bench for combi_fetch: a table of per-cycle vectors followed by a
// hand-written asynchronous-reset sequence. Memory returns addr+0x1000_0000.
module tb_combi_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD, FlushD, PCSrcE, armD;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        wasNotFlushedD, ArmModeD, FetchBusyF;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  combi_fetch_if imem ();

  assign imem.ImemRdata = imem.ImemAddr + 32'h1000_0000;

  combi_fetch #(
    .RESET_PC  (32'h0000_0000),
    .ARM_RESET (1'b0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ImemAddr       (imem.ImemAddr),
    .ImemReq        (imem.ImemReq),
    .ImemRdata      (imem.ImemRdata),
    .ImemValid      (imem.ImemValid),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .armD           (armD),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .wasNotFlushedD (wasNotFlushedD),
    .ArmModeD       (ArmModeD),
    .FetchBusyF     (FetchBusyF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s, f, p;
    logic [31:0] tgt;
    logic        val, arm;
    logic [31:0] e_addr;
    logic        e_req, e_busy;
    logic [31:0] e_instr, e_pcd, e_pp4;
    logic        e_wnf, e_arm;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic s, logic f, logic p, logic [31:0] tgt, logic val, logic arm,
                             logic [31:0] addr, logic req, logic busy,
                             logic [31:0] instr, logic [31:0] pcd, logic [31:0] pp4,
                             logic wnf, logic armo);
    vec_t r;
    r.s = s; r.f = f; r.p = p; r.tgt = tgt; r.val = val; r.arm = arm;
    r.e_addr = addr; r.e_req = req; r.e_busy = busy;
    r.e_instr = instr; r.e_pcd = pcd; r.e_pp4 = pp4; r.e_wnf = wnf; r.e_arm = armo;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ImemAddr"},  imem.ImemAddr, 32'h0);
    chk({tag, " ImemReq"},   32'(imem.ImemReq), 32'h0);
    chk({tag, " InstrD"},    InstrD, 32'h0);
    chk({tag, " PCD"},       PCD, 32'h0);
    chk({tag, " PCPlus4D"},  PCPlus4D, 32'h0);
    chk({tag, " wnf"},       32'(wasNotFlushedD), 32'h0);
    chk({tag, " ArmModeD"},  32'(ArmModeD), 32'h0);
    chk({tag, " FetchBusy"}, 32'(FetchBusyF), 32'h1);
  endtask

  initial begin
    reset = 1'b1; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0; armD = 0;
    imem.ImemValid = 1'b0;

    //      s f p tgt           val arm | addr        req busy | instr         pcd           pp4           wnf arm
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'h0,        0,1, 32'h0,        32'h0,        32'h0,        0,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'h0,        1,0, 32'h1000_0000,32'h0,        32'h4,        1,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'h4,        1,0, 32'h1000_0004,32'h4,        32'h8,        1,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'h8,        1,0, 32'h1000_0008,32'h8,        32'hC,        1,0));
    vq.push_back(v(0,0,0,32'h0,        0,0, 32'hC,        1,1, 32'h0,        32'h8,        32'hC,        0,0));
    vq.push_back(v(0,0,0,32'h0,        0,0, 32'hC,        1,1, 32'h0,        32'h8,        32'hC,        0,0));
    vq.push_back(v(0,0,0,32'h0,        0,0, 32'hC,        1,1, 32'h0,        32'h8,        32'hC,        0,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'hC,        1,0, 32'h1000_000C,32'hC,        32'h10,       1,0));
    vq.push_back(v(1,0,0,32'h0,        1,0, 32'h10,       1,0, 32'h1000_000C,32'hC,        32'h10,       1,0));
    vq.push_back(v(1,0,0,32'h0,        0,0, 32'h10,       0,0, 32'h1000_000C,32'hC,        32'h10,       1,0));
    vq.push_back(v(0,0,0,32'h0,        0,0, 32'h10,       0,0, 32'h1000_0010,32'h10,       32'h14,       1,0));
    vq.push_back(v(0,1,0,32'h0,        1,0, 32'h14,       1,0, 32'h0,        32'h10,       32'h14,       0,0));
    vq.push_back(v(0,0,0,32'h0,        0,0, 32'h14,       0,0, 32'h1000_0014,32'h14,       32'h18,       1,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'h18,       1,0, 32'h1000_0018,32'h18,       32'h1C,       1,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'h1C,       1,0, 32'h1000_001C,32'h1C,       32'h20,       1,0));
    vq.push_back(v(0,0,1,32'h100,      0,0, 32'h20,       1,0, 32'h0,        32'h1C,       32'h20,       0,0));
    vq.push_back(v(0,0,0,32'h0,        0,0, 32'h20,       1,1, 32'h0,        32'h1C,       32'h20,       0,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'h20,       1,1, 32'h0,        32'h1C,       32'h20,       0,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'h100,      1,0, 32'h1000_0100,32'h100,      32'h104,      1,0));
    vq.push_back(v(0,0,0,32'h0,        1,1, 32'h104,      1,0, 32'h1000_0104,32'h104,      32'h108,      1,1));
    vq.push_back(v(1,0,0,32'h0,        0,0, 32'h108,      1,0, 32'h1000_0104,32'h104,      32'h108,      1,1));
    vq.push_back(v(1,0,0,32'h0,        0,0, 32'h108,      1,0, 32'h1000_0104,32'h104,      32'h108,      1,1));
    vq.push_back(v(0,0,0,32'h0,        0,0, 32'h108,      1,1, 32'h0,        32'h104,      32'h108,      0,0));
    vq.push_back(v(0,0,1,32'hFFFF_FFF8,1,0, 32'h108,      1,0, 32'h0,        32'h104,      32'h108,      0,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'hFFFF_FFF8,1,0, 32'h0FFF_FFF8,32'hFFFF_FFF8,32'hFFFF_FFFC,1,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'hFFFF_FFFC,1,0, 32'h0FFF_FFFC,32'hFFFF_FFFC,32'h0,        1,0));
    vq.push_back(v(0,0,0,32'h0,        0,0, 32'h0,        1,1, 32'h0,        32'hFFFF_FFFC,32'h0,        0,0));
    vq.push_back(v(1,0,0,32'h0,        1,0, 32'h0,        1,0, 32'h0,        32'hFFFF_FFFC,32'h0,        0,0));
    vq.push_back(v(1,0,1,32'h200,      0,0, 32'h0,        0,0, 32'h0,        32'hFFFF_FFFC,32'h0,        0,0));
    vq.push_back(v(0,0,0,32'h0,        1,0, 32'h200,      1,0, 32'h1000_0200,32'h200,      32'h204,      1,0));
    vq.push_back(v(0,0,0,32'h0,        0,0, 32'h204,      1,1, 32'h0,        32'h200,      32'h204,      0,0));

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst0");
    reset = 1'b0;

    foreach (vq[i]) begin
      StallD = vq[i].s; FlushD = vq[i].f; PCSrcE = vq[i].p;
      PCTargetE = vq[i].tgt; imem.ImemValid = vq[i].val; armD = vq[i].arm;
      #1;
      chk($sformatf("v%0d ImemAddr", i),   imem.ImemAddr, vq[i].e_addr);
      chk($sformatf("v%0d ImemReq", i),    32'(imem.ImemReq), 32'(vq[i].e_req));
      chk($sformatf("v%0d FetchBusyF", i), 32'(FetchBusyF), 32'(vq[i].e_busy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d InstrD", i),     InstrD, vq[i].e_instr);
      chk($sformatf("v%0d PCD", i),        PCD, vq[i].e_pcd);
      chk($sformatf("v%0d PCPlus4D", i),   PCPlus4D, vq[i].e_pp4);
      chk($sformatf("v%0d wnf", i),        32'(wasNotFlushedD), 32'(vq[i].e_wnf));
      chk($sformatf("v%0d ArmModeD", i),   32'(ArmModeD), 32'(vq[i].e_arm));
    end

    // Asynchronous reset while the request at 0x204 is still pending.
    StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0; armD = 1'b1;
    imem.ImemValid = 1'b0;
    chk("pend ImemReq", 32'(imem.ImemReq), 32'h1);
    #2 reset = 1'b1;
    armD = 1'b0;
    #1;
    chk_reset_state("rstA");

    // Late ImemValid arriving in IDLE must be ignored.
    @(posedge clk);
    #1;
    reset = 1'b0;
    imem.ImemValid = 1'b1;
    #1;
    chk("idle ImemReq",  32'(imem.ImemReq), 32'h0);
    chk("idle ImemAddr", imem.ImemAddr, 32'h0);
    @(posedge clk);
    #1;
    chk("post ImemReq",  32'(imem.ImemReq), 32'h1);
    chk("post ImemAddr", imem.ImemAddr, 32'h0);
    chk("post InstrD",   InstrD, 32'h0);
    chk("post wnf",      32'(wasNotFlushedD), 32'h0);
    @(posedge clk);
    #1;
    chk("first InstrD",  InstrD, 32'h1000_0000);
    chk("first PCD",     PCD, 32'h0);
    chk("first wnf",     32'(wasNotFlushedD), 32'h1);
    chk("next ImemAddr", imem.ImemAddr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
